// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter: IF/DM arbiter onto one memory port, DM priority, with timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic              if_stall,
  output logic              dm_stall,
  output logic              bus_err
);

  localparam logic [1:0] C_IDLE     = 2'd0;
  localparam logic [1:0] C_SERVE_IF = 2'd1;
  localparam logic [1:0] C_SERVE_DM = 2'd2;

  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);

  logic [1:0]        state_q,    state_d;
  logic [7:0]        cnt_q,      cnt_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              we_q,       we_d;
  logic              if_ack_q,   if_ack_d;
  logic              dm_ack_q,   dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              bus_err_q,  bus_err_d;

  logic [7:0]        w_cnt_inc;
  logic              w_serve_dm;

  assign w_cnt_inc  = cnt_q + 8'd1;
  assign w_serve_dm = (state_q == C_SERVE_DM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      C_IDLE: begin
        // A requester still seeing its ack is finishing, not asking again.
        if (dm_req && !dm_ack_q) begin
          state_d = C_SERVE_DM;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          we_d    = dm_wen;
          cnt_d   = 8'd0;
        end else if (if_req && !if_ack_q) begin
          state_d = C_SERVE_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
        end
      end

      C_SERVE_IF, C_SERVE_DM: begin
        if (mem_ack) begin
          state_d = C_IDLE;
          if (w_serve_dm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (w_cnt_inc == C_TIMEOUT) begin
          // Release the requester with zero data and flag the error.
          state_d   = C_IDLE;
          cnt_d     = w_cnt_inc;
          bus_err_d = 1'b1;
          if (w_serve_dm) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_cs    = (state_q != C_IDLE);
  assign mem_we    = we_q & mem_cs;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

  assign if_stall  = if_req & ~if_ack_q;
  assign dm_stall  = dm_req & ~dm_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (default TIMEOUT)
  logic          rst, if_req, dm_req, dm_wen;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          mem_ack;
  logic          if_ack, dm_ack, mem_cs, mem_we, if_stall, dm_stall, bus_err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  // timeout DUT (TIMEOUT = 4)
  logic          t_rst, t_if_req, t_dm_req, t_dm_wen, t_mem_ack;
  logic [AW-1:0] t_if_addr, t_dm_addr;
  logic [DW-1:0] t_dm_wdata, t_mem_rdata;
  logic          t_if_ack, t_dm_ack, t_mem_cs, t_mem_we, t_if_stall, t_dm_stall, t_bus_err;
  logic [DW-1:0] t_if_rdata, t_dm_rdata, t_mem_wdata;
  logic [AW-1:0] t_mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .if_stall(if_stall), .dm_stall(dm_stall), .bus_err(bus_err)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) u_to (
    .clk(clk), .rst(t_rst),
    .if_req(t_if_req), .if_addr(t_if_addr), .if_ack(t_if_ack), .if_rdata(t_if_rdata),
    .dm_req(t_dm_req), .dm_wen(t_dm_wen), .dm_addr(t_dm_addr), .dm_wdata(t_dm_wdata),
    .dm_ack(t_dm_ack), .dm_rdata(t_dm_rdata),
    .mem_cs(t_mem_cs), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata), .mem_ack(t_mem_ack),
    .if_stall(t_if_stall), .dm_stall(t_dm_stall), .bus_err(t_bus_err)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_if[$];
  exp_t q_dm[$];
  exp_t q_to[$];

  // memory responder controls for the main DUT
  int            ack_lat   = 1;
  logic [DW-1:0] rd_val    = '0;
  logic          force_ack = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder: ack on the ack_lat-th cycle of mem_cs (1 = same cycle as first cs).
  initial begin
    int k;
    k         = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      k         = mem_cs ? k + 1 : 0;
      mem_ack   = force_ack | (mem_cs && (k == ack_lat));
      mem_rdata = rd_val;
    end
  end

  // Monitor: every ack pops and checks one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_ack) begin
        if (q_if.size() == 0) chk("if_ack_unexpected", 1, 0);
        else begin
          e = q_if.pop_front();
          chk("if_rdata", if_rdata, e.data);
          chk("if_bus_err", bus_err, e.err);
        end
      end
      if (dm_ack) begin
        if (q_dm.size() == 0) chk("dm_ack_unexpected", 1, 0);
        else begin
          e = q_dm.pop_front();
          chk("dm_rdata", dm_rdata, e.data);
          chk("dm_bus_err", bus_err, e.err);
        end
      end
      if (bus_err && !if_ack && !dm_ack) chk("bus_err_without_ack", 1, 0);
    end
    if (!t_rst) begin
      if (t_dm_ack) begin
        if (q_to.size() == 0) chk("t_dm_ack_unexpected", 1, 0);
        else begin
          e = q_to.pop_front();
          chk("t_dm_rdata", t_dm_rdata, e.data);
          chk("t_bus_err", t_bus_err, e.err);
        end
      end
      if (t_if_ack) chk("t_if_ack_unexpected", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wen = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    t_rst = 1'b1; t_if_req = 1'b0; t_dm_req = 1'b0; t_dm_wen = 1'b0;
    t_if_addr = '0; t_dm_addr = '0; t_dm_wdata = '0; t_mem_ack = 1'b0; t_mem_rdata = '0;

    repeat (3) tick();
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0; t_rst = 1'b0;
    tick();

    // single fetch, minimum latency
    rd_val = 32'h2402000A; ack_lat = 1;
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    q_if.push_back('{data: 32'h2402000A, err: 1'b0});
    #1;
    chk("f_c0_stall", if_stall, 1);
    chk("f_c0_cs", mem_cs, 0);
    tick(); #1;
    chk("f_c1_cs", mem_cs, 1);
    chk("f_c1_addr", mem_addr, 32'h100);
    chk("f_c1_we", mem_we, 0);
    chk("f_c1_stall", if_stall, 1);
    chk("f_c1_ack", if_ack, 0);
    tick(); #1;
    chk("f_c2_ack", if_ack, 1);
    chk("f_c2_rdata", if_rdata, 32'h2402000A);
    chk("f_c2_stall", if_stall, 0);
    chk("f_c2_cs", mem_cs, 0);
    tick();
    if_req = 1'b0;
    #1;
    chk("f_c3_no_regrant", mem_cs, 0);
    chk("f_c3_ack_low", if_ack, 0);
    tick(); #1;
    chk("f_c4_cs", mem_cs, 0);

    // simultaneous IF and DM write: DM first
    rd_val = 32'h12345678; ack_lat = 1;
    tick();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    q_dm.push_back('{data: 32'h12345678, err: 1'b0});
    q_if.push_back('{data: 32'h12345678, err: 1'b0});
    #1;
    chk("p_c0_dm_stall", dm_stall, 1);
    chk("p_c0_if_stall", if_stall, 1);
    tick(); #1;
    chk("p_c1_cs", mem_cs, 1);
    chk("p_c1_we", mem_we, 1);
    chk("p_c1_addr", mem_addr, 32'h40);
    chk("p_c1_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); #1;
    chk("p_c2_dm_ack", dm_ack, 1);
    chk("p_c2_if_ack", if_ack, 0);
    chk("p_c2_if_stall", if_stall, 1);
    tick();
    dm_req = 1'b0; dm_wen = 1'b0;
    #1;
    chk("p_c3_cs", mem_cs, 1);
    chk("p_c3_addr", mem_addr, 32'h200);
    chk("p_c3_we", mem_we, 0);
    tick(); #1;
    chk("p_c4_if_ack", if_ack, 1);
    chk("p_c4_dm_ack", dm_ack, 0);
    if_req = 1'b0;
    tick(); #1;
    chk("p_c5_cs", mem_cs, 0);

    // DM read with ack on the sixth cs cycle; address input moves mid-access
    rd_val = 32'hCAFEF00D; ack_lat = 6;
    tick();
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0;
    q_dm.push_back('{data: 32'hCAFEF00D, err: 1'b0});
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) begin dm_addr = 32'hFFF; dm_wen = 1'b1; end
      #1;
      chk("s_cs", mem_cs, 1);
      chk("s_addr", mem_addr, 32'h80);
      chk("s_we", mem_we, 0);
      chk("s_dm_ack", dm_ack, 0);
    end
    chk("s_c6_stall", dm_stall, 1);
    tick(); #1;
    chk("s_c7_dm_ack", dm_ack, 1);
    chk("s_c7_stall", dm_stall, 0);
    chk("s_c7_cs", mem_cs, 0);
    dm_req = 1'b0; dm_wen = 1'b0;
    tick(); #1;
    chk("s_c8_cs", mem_cs, 0);

    // reset during SERVE_IF abandons the access
    ack_lat = 20;
    tick();
    if_req = 1'b1; if_addr = 32'h300;
    tick(); #1;
    chk("r_c1_cs", mem_cs, 1);
    chk("r_c1_addr", mem_addr, 32'h300);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; if_req = 1'b0;
    #1;
    chk("r_c3_cs", mem_cs, 0);
    chk("r_c3_ack", if_ack, 0);
    tick(); #1;
    chk("r_c4_cs", mem_cs, 0);
    chk("r_c4_ack", if_ack, 0);
    rd_val = 32'hA5A5A5A5; ack_lat = 1;
    tick();
    if_req = 1'b1; if_addr = 32'h304;
    q_if.push_back('{data: 32'hA5A5A5A5, err: 1'b0});
    tick(); #1;
    chk("r_n1_cs", mem_cs, 1);
    chk("r_n1_addr", mem_addr, 32'h304);
    tick(); #1;
    chk("r_n2_ack", if_ack, 1);
    if_req = 1'b0;
    tick();

    // mem_ack while idle has no effect
    force_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      chk("i_cs", mem_cs, 0);
      chk("i_if_ack", if_ack, 0);
      chk("i_dm_ack", dm_ack, 0);
    end
    force_ack = 1'b0;
    tick();

    // TIMEOUT=4 instance: normal access, then a timed-out one
    tick();
    t_dm_req = 1'b1; t_dm_wen = 1'b0; t_dm_addr = 32'h44;
    q_to.push_back('{data: 32'h77, err: 1'b0});
    tick();
    t_mem_ack = 1'b1; t_mem_rdata = 32'h77;
    #1;
    chk("t_ok_cs", t_mem_cs, 1);
    tick();
    t_mem_ack = 1'b0; t_mem_rdata = 32'h0;
    #1;
    chk("t_ok_ack", t_dm_ack, 1);
    t_dm_req = 1'b0;
    tick(); #1;
    chk("t_ok_cs_low", t_mem_cs, 0);
    tick();
    t_dm_req = 1'b1; t_dm_addr = 32'h48;
    q_to.push_back('{data: 32'h0, err: 1'b1});
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      chk("t_wait_cs", t_mem_cs, 1);
      chk("t_wait_addr", t_mem_addr, 32'h48);
      chk("t_wait_ack", t_dm_ack, 0);
      chk("t_wait_err", t_bus_err, 0);
    end
    tick(); #1;
    chk("t_to_ack", t_dm_ack, 1);
    chk("t_to_err", t_bus_err, 1);
    chk("t_to_rdata", t_dm_rdata, 0);
    chk("t_to_cs", t_mem_cs, 0);
    t_dm_req = 1'b0;
    tick(); #1;
    chk("t_after_cs", t_mem_cs, 0);
    chk("t_after_err", t_bus_err, 0);
    repeat (2) tick();

    chk("sb_if_empty", q_if.size(), 0);
    chk("sb_dm_empty", q_dm.size(), 0);
    chk("sb_to_empty", q_to.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
